hpi_xact_ctrl: RTL and testbench



---
 rtl/hpi_pkg.sv | 31 +++
 rtl/hpi_irq_sync.sv | 38 +++
 rtl/hpi_xact_ctrl.sv | 133 +++++++++++++
 tb/tb_hpi_xact_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// ============================================================================
// Module      : hpi_pkg
// Description : Shared types for the HPI transaction engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpi_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 2;
    // Phase counter width; phase lengths up to 256 cycles.
    localparam int CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } hpi_state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } hpi_req_t;

endpackage

`default_nettype wire

// File: rtl/hpi_irq_sync.sv
// ============================================================================
// Module      : hpi_irq_sync
// Description : Two-flop synchroniser, rising-edge detect, sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpi_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic clear,
    output logic pending
);

    // sync[1:0] form the synchroniser, sync[2] is the previous synchronised value
    logic [2:0] sync;
    logic       rise;

    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 3'b000;
            pending <= 1'b0;
        end else begin
            sync <= {sync[1:0], async_in};
            if (rise) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hpi_xact_ctrl.sv
// ============================================================================
// Module      : hpi_xact_ctrl
// Description : Timed HPI read/write engine for the CY7C67200 OTG chip.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpi_xact_ctrl
    import hpi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 2,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              irq_pending,
    input  logic              irq_clear,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic [ADDR_W-1:0] OTG_ADDR,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_CS_N,
    output logic              OTG_RST_N,
    input  logic              OTG_INT
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    hpi_state_t       state;
    hpi_state_t       nxt;
    logic [CNT_W-1:0] cnt;
    req_t             req;
    logic             drive;
    logic             accept;
    logic             cur_write;
    logic             xact_on;
    logic             strobe_end;

    function automatic logic [CNT_W-1:0] load_for(input hpi_state_t s);
        case (s)
            SETUP:   return CNT_W'(SETUP_CYC - 1);
            STROBE:  return CNT_W'(STROBE_CYC - 1);
            HOLD:    return CNT_W'(HOLD_CYC - 1);
            RECOVER: return CNT_W'(RECOVER_CYC - 1);
            default: return '0;
        endcase
    endfunction

    // Zero-length phases are skipped by choosing the next non-empty state.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req_valid) nxt = (SETUP_CYC > 0) ? SETUP : STROBE;
            SETUP:   if (cnt == '0) nxt = STROBE;
            STROBE:  if (cnt == '0) nxt = (HOLD_CYC > 0) ? HOLD :
                                          (RECOVER_CYC > 0) ? RECOVER : IDLE;
            HOLD:    if (cnt == '0) nxt = (RECOVER_CYC > 0) ? RECOVER : IDLE;
            RECOVER: if (cnt == '0) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && req_valid;
    assign cur_write  = accept ? req_write : req.write;
    assign xact_on    = nxt inside {SETUP, STROBE, HOLD};
    assign strobe_end = (state == STROBE) && (nxt != STROBE);

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req       <= '0;
            drive     <= 1'b0;
            OTG_CS_N  <= 1'b1;
            OTG_RD_N  <= 1'b1;
            OTG_WR_N  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                cnt <= load_for(nxt);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (accept) begin
                req <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            end
            OTG_CS_N  <= ~xact_on;
            OTG_RD_N  <= ~((nxt == STROBE) && !cur_write);
            OTG_WR_N  <= ~((nxt == STROBE) && cur_write);
            drive     <= xact_on && cur_write;
            rsp_valid <= strobe_end;
            if (strobe_end && !req.write) begin
                rsp_rdata <= OTG_DATA;
            end
        end
    end

    assign OTG_ADDR  = req.addr;
    assign OTG_DATA  = drive ? req.wdata : {DATA_W{1'bz}};
    assign OTG_RST_N = ~Reset;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    hpi_irq_sync u_irq_sync (
        .clk      (Clk),
        .rst      (Reset),
        .async_in (OTG_INT),
        .clear    (irq_clear),
        .pending  (irq_pending)
    );

endmodule

`default_nettype wire

// File: tb/tb_hpi_xact_ctrl.sv
// ============================================================================
// Module      : tb_hpi_xact_ctrl
// Description : Directed self-checking bench for hpi_xact_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpi_xact_ctrl;

    logic        clk;
    logic        rst;

    // default-parameter instance
    logic        req_valid, req_write, irq_clear, otg_int;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready, rsp_valid, busy, irq_pending;
    logic [15:0] rsp_rdata;
    logic [1:0]  otg_addr;
    logic        rd_n, wr_n, cs_n, otg_rst_n;
    logic        mdrv;
    logic [15:0] mval;
    wire  [15:0] otg_data;
    assign otg_data = mdrv ? mval : 16'hzzzz;

    // zero-gap instance
    logic        b_req_valid, b_req_write, b_irq_clear, b_otg_int;
    logic [1:0]  b_req_addr;
    logic [15:0] b_req_wdata;
    logic        b_req_ready, b_rsp_valid, b_busy, b_irq_pending;
    logic [15:0] b_rsp_rdata;
    logic [1:0]  b_otg_addr;
    logic        b_rd_n, b_wr_n, b_cs_n, b_otg_rst_n;
    logic        b_mdrv;
    logic [15:0] b_mval;
    wire  [15:0] b_otg_data;
    assign b_otg_data = b_mdrv ? b_mval : 16'hzzzz;

    int n_checks;
    int n_fail;

    hpi_xact_ctrl dut (
        .Clk(clk), .Reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .irq_pending(irq_pending), .irq_clear(irq_clear),
        .OTG_DATA(otg_data), .OTG_ADDR(otg_addr), .OTG_RD_N(rd_n),
        .OTG_WR_N(wr_n), .OTG_CS_N(cs_n), .OTG_RST_N(otg_rst_n), .OTG_INT(otg_int)
    );

    hpi_xact_ctrl #(
        .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .RECOVER_CYC(0)
    ) dut_b (
        .Clk(clk), .Reset(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
        .irq_pending(b_irq_pending), .irq_clear(b_irq_clear),
        .OTG_DATA(b_otg_data), .OTG_ADDR(b_otg_addr), .OTG_RD_N(b_rd_n),
        .OTG_WR_N(b_wr_n), .OTG_CS_N(b_cs_n), .OTG_RST_N(b_otg_rst_n), .OTG_INT(b_otg_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        irq_clear = 0; otg_int = 0; mdrv = 1; mval = 16'h0000;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
        b_irq_clear = 0; b_otg_int = 0; b_mdrv = 1; b_mval = 16'h0000;

        tick(); tick();
        check("rst_n_in_reset", otg_rst_n, 0);
        rst = 1'b0;
        tick(); #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_addr", otg_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_irq", irq_pending, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_otg_rst_n", otg_rst_n, 1);
        check("rst_bus_z", otg_data, 16'h0000);

        // write addr=2 data=A5C3; cycle 0 is the accept cycle
        req_valid = 1; req_write = 1; req_addr = 2; req_wdata = 16'hA5C3; mdrv = 0;
        check("wr_ready_c0", req_ready, 1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_valid = 0;
            mdrv = (c >= 7);
            #1;
            check($sformatf("wr_cs_n_c%0d", c), cs_n, (c > 6));
            check($sformatf("wr_wr_n_c%0d", c), wr_n, !(c >= 2 && c <= 5));
            check($sformatf("wr_rd_n_c%0d", c), rd_n, 1);
            check($sformatf("wr_rsp_c%0d", c), rsp_valid, (c == 6));
            check($sformatf("wr_ready_c%0d", c), req_ready, (c == 9));
            check($sformatf("wr_data_c%0d", c), otg_data, (c <= 6) ? 16'hA5C3 : 16'h0000);
            if (c <= 6) check($sformatf("wr_addr_c%0d", c), otg_addr, 2);
        end

        // read addr=1, model drives 1234 during strobe
        req_valid = 1; req_write = 0; req_addr = 1; mdrv = 1; mval = 16'h0000;
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_valid = 0;
            mval = (c >= 2 && c <= 5) ? 16'h1234 : 16'h0000;
            #1;
            check($sformatf("rd_rd_n_c%0d", c), rd_n, !(c >= 2 && c <= 5));
            check($sformatf("rd_wr_n_c%0d", c), wr_n, 1);
            check($sformatf("rd_cs_n_c%0d", c), cs_n, (c > 6));
            check($sformatf("rd_bus_c%0d", c), otg_data, (c >= 2 && c <= 5) ? 16'h1234 : 16'h0000);
            check($sformatf("rd_rsp_c%0d", c), rsp_valid, (c == 6));
            if (c == 1) check("rd_addr", otg_addr, 1);
            if (c == 6 || c == 9) check($sformatf("rd_rdata_c%0d", c), rsp_rdata, 16'h1234);
        end

        // reset in the middle of a write strobe
        req_valid = 1; req_write = 1; req_addr = 3; req_wdata = 16'h5AA5; mdrv = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            req_valid = 0;
        end
        #1;
        check("abort_pre_wr_n", wr_n, 0);
        rst = 1'b1;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_wr_n", wr_n, 1);
        check("abort_rsp", rsp_valid, 0);
        check("abort_busy", busy, 0);
        mdrv = 1; mval = 16'h0000;
        #1;
        check("abort_bus_z", otg_data, 16'h0000);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick(); #1;
            check($sformatf("abort_post_rsp_c%0d", c), rsp_valid, 0);
            check($sformatf("abort_post_ready_c%0d", c), req_ready, 1);
            check($sformatf("abort_post_cs_n_c%0d", c), cs_n, 1);
        end

        // zero-gap instance: back-to-back reads with req_valid held
        b_req_valid = 1; b_req_write = 0; b_req_addr = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            b_mval = (c == 1) ? 16'hBEEF : (c == 3) ? 16'h0C0D : 16'h0000;
            if (c == 4) b_req_valid = 0;
            #1;
            check($sformatf("b2b_rd_n_c%0d", c), b_rd_n, !(c == 1 || c == 3));
            check($sformatf("b2b_cs_n_c%0d", c), b_cs_n, !(c == 1 || c == 3));
            check($sformatf("b2b_wr_n_c%0d", c), b_wr_n, 1);
            check($sformatf("b2b_rsp_c%0d", c), b_rsp_valid, (c == 2 || c == 4));
            check($sformatf("b2b_ready_c%0d", c), b_req_ready, (c != 1 && c != 3));
            check($sformatf("b2b_busy_c%0d", c), b_busy, (c == 1 || c == 3));
            if (c == 2) check("b2b_rdata_1", b_rsp_rdata, 16'hBEEF);
            if (c == 4) check("b2b_rdata_2", b_rsp_rdata, 16'h0C0D);
        end
        check("b2b_addr", b_otg_addr, 0);
        check("b2b_irq", b_irq_pending, 0);
        check("b2b_rst_n", b_otg_rst_n, 1);

        // interrupt: 3-cycle pulse
        otg_int = 1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 3) otg_int = 0;
            #1;
            check($sformatf("irq_pulse_c%0d", c), irq_pending, (c >= 3));
        end
        irq_clear = 1;
        tick(); irq_clear = 0; #1;
        check("irq_cleared", irq_pending, 0);

        // level held high must not re-set after a clear
        otg_int = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            irq_clear = (c == 3);
            #1;
            check($sformatf("irq_level_c%0d", c), irq_pending, (c == 3));
        end

        // new rise coincident with clear: set wins
        otg_int = 0;
        repeat (4) tick();
        otg_int = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            irq_clear = (c == 2);
            #1;
            check($sformatf("irq_setwins_c%0d", c), irq_pending, (c == 3));
        end
        irq_clear = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
